if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 111 +++++++++++
 tb/tb_if_fetch_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and IF/ID register with stall, redirect/flush, halt and fault (optional perf counters via IF_PERF_CNT_EN)
module if_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int IMEM_BYTES = 51,
  parameter logic [15:0] HALT_IR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_ir,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        ifid_valid,
  output logic [15:0] ifid_ir,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_plus2,
  output logic        halted,
  output logic        fetch_fault,
  output logic [15:0] perf_fetch,
  output logic [15:0] perf_stall,
  output logic [15:0] perf_flush
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;
  localparam logic [16:0] LAST = 17'(IMEM_BYTES - 1);
  state_t state, state_n;
  logic [15:0] pc, pc_n;
  logic cap, clr, flt, flush, stl, legal;
  assign imem_addr = pc;
  assign halted = (state == HALT) || (state == FAULT);
  assign legal = ({1'b0, pc} + 17'd1) <= LAST;
  always_comb begin
    state_n = state;
    pc_n = pc;
    cap = 1'b0;
    clr = 1'b0;
    flt = 1'b0;
    flush = 1'b0;
    stl = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (redirect_valid) begin
          pc_n = {redirect_pc[15:1], 1'b0};
          clr = 1'b1;
          flush = 1'b1;
        end else if (stall) begin
          stl = 1'b1;
        end else if (!legal) begin
          clr = 1'b1;
          flt = 1'b1;
          state_n = FAULT;
        end else begin
          cap = 1'b1;
          pc_n = (imem_ir == HALT_IR) ? pc : pc + 16'd2;
          state_n = (imem_ir == HALT_IR) ? HALT : RUN;
        end
      end
      default: begin
        if (redirect_valid) begin
          pc_n = {redirect_pc[15:1], 1'b0};
          clr = 1'b1;
          flush = 1'b1;
          state_n = RUN;
        end else begin
          clr = !stall;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc <= {RESET_PC[15:1], 1'b0};
      ifid_valid <= 1'b0;
      ifid_ir <= 16'h0;
      ifid_pc <= 16'h0;
      ifid_pc_plus2 <= 16'h0;
      fetch_fault <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      fetch_fault <= fetch_fault | flt;
      if (cap) begin
        ifid_valid <= 1'b1;
        ifid_ir <= imem_ir;
        ifid_pc <= pc;
        ifid_pc_plus2 <= pc + 16'd2;
      end else if (clr) begin
        ifid_valid <= 1'b0;
      end
    end
  end
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= 16'h0;
      perf_stall <= 16'h0;
      perf_flush <= 16'h0;
    end else begin
      perf_fetch <= perf_fetch + 16'(cap && perf_fetch != 16'hFFFF);
      perf_stall <= perf_stall + 16'(stl && perf_stall != 16'hFFFF);
      perf_flush <= perf_flush + 16'(flush && perf_flush != 16'hFFFF);
    end
  end
`else
  assign perf_fetch = 16'h0;
  assign perf_stall = 16'h0;
  assign perf_flush = 16'h0;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: table-driven directed check of if_fetch_stage with a small behavioural instruction memory
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic rst, stall, redirect_valid;
  logic [15:0] redirect_pc, imem_addr, imem_ir;
  logic ifid_valid, halted, fetch_fault;
  logic [15:0] ifid_ir, ifid_pc, ifid_pc_plus2, perf_fetch, perf_stall, perf_flush;
  logic [15:0] mem [0:31];
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic rst, stall, rv;
    logic [15:0] rpc;
    logic v;
    logic [15:0] ir, pc, addr;
    logic h, f;
    logic [15:0] pf, ps, pl;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  assign imem_ir = (imem_addr[15:1] < 15'd26) ? mem[imem_addr[5:1]] : 16'h0000;

  if_fetch_stage #(.RESET_PC(16'h0000), .IMEM_BYTES(51), .HALT_IR(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_ir(imem_ir), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ifid_valid(ifid_valid),
    .ifid_ir(ifid_ir), .ifid_pc(ifid_pc), .ifid_pc_plus2(ifid_pc_plus2), .halted(halted),
    .fetch_fault(fetch_fault), .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, s, rv, input logic [15:0] rpc, input logic v,
                     input logic [15:0] ir, pc, addr, input logic h, f, input logic [15:0] pf, ps, pl);
    vec_t t;
    t = '{r, s, rv, rpc, v, ir, pc, addr, h, f, pf, ps, pl};
    tv.push_back(t);
  endtask

  task automatic step(input logic r, s, rv, input logic [15:0] rpc);
    @(negedge clk);
    rst = r;
    stall = s;
    redirect_valid = rv;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic perf_chk(input string tag, input logic [15:0] pf, ps, pl);
`ifdef IF_PERF_CNT_EN
    chk({tag, " perf_fetch"}, 32'(perf_fetch), 32'(pf));
    chk({tag, " perf_stall"}, 32'(perf_stall), 32'(ps));
    chk({tag, " perf_flush"}, 32'(perf_flush), 32'(pl));
`else
    chk({tag, " perf_fetch"}, 32'(perf_fetch), 32'(pf & 16'h0));
    chk({tag, " perf_stall"}, 32'(perf_stall), 32'(ps & 16'h0));
    chk({tag, " perf_flush"}, 32'(perf_flush), 32'(pl & 16'h0));
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h43CA;
    mem[1] = 16'h45CC;
    mem[3] = 16'hFFFF;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0;
    //  rst stall rv rpc      v  ir        pc        addr      h  f  pf  ps pl
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h43CA, 16'h0000, 16'h0002, 0, 0, 1, 0, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h45CC, 16'h0002, 16'h0004, 0, 0, 2, 0, 0);
    add(0, 1, 0, 16'h0000, 1, 16'h45CC, 16'h0002, 16'h0004, 0, 0, 2, 1, 0);
    add(0, 1, 0, 16'h0000, 1, 16'h45CC, 16'h0002, 16'h0004, 0, 0, 2, 2, 0);
    add(0, 1, 0, 16'h0000, 1, 16'h45CC, 16'h0002, 16'h0004, 0, 0, 2, 3, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h1002, 16'h0004, 16'h0006, 0, 0, 3, 3, 0);
    add(0, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h0006, 16'h0006, 1, 0, 4, 3, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0006, 1, 0, 4, 3, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0006, 1, 0, 4, 3, 0);
    add(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 4, 3, 1);
    add(0, 0, 0, 16'h0000, 1, 16'h43CA, 16'h0000, 16'h0002, 0, 0, 5, 3, 1);
    add(0, 1, 1, 16'h0029, 0, 16'h0000, 16'h0000, 16'h0028, 0, 0, 5, 3, 2);
    add(0, 0, 0, 16'h0000, 1, 16'h1014, 16'h0028, 16'h002A, 0, 0, 6, 3, 2);
    add(0, 0, 0, 16'h0000, 1, 16'h1015, 16'h002A, 16'h002C, 0, 0, 7, 3, 2);
    add(0, 0, 0, 16'h0000, 1, 16'h1016, 16'h002C, 16'h002E, 0, 0, 8, 3, 2);
    add(0, 0, 0, 16'h0000, 1, 16'h1017, 16'h002E, 16'h0030, 0, 0, 9, 3, 2);
    add(0, 0, 0, 16'h0000, 1, 16'h1018, 16'h0030, 16'h0032, 0, 0, 10, 3, 2);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0032, 1, 1, 10, 3, 2);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0032, 1, 1, 10, 3, 2);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0032, 1, 1, 10, 3, 2);
    add(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 10, 3, 3);
    add(0, 0, 0, 16'h0000, 1, 16'h43CA, 16'h0000, 16'h0002, 0, 1, 11, 3, 3);
    add(0, 0, 0, 16'h0000, 1, 16'h45CC, 16'h0002, 16'h0004, 0, 1, 12, 3, 3);
    add(1, 1, 1, 16'h0010, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 1, 16'h43CA, 16'h0000, 16'h0002, 0, 0, 1, 0, 0);
    foreach (tv[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      step(tv[i].rst, tv[i].stall, tv[i].rv, tv[i].rpc);
      chk({tag, " ifid_valid"}, 32'(ifid_valid), 32'(tv[i].v));
      chk({tag, " imem_addr"}, 32'(imem_addr), 32'(tv[i].addr));
      chk({tag, " halted"}, 32'(halted), 32'(tv[i].h));
      chk({tag, " fetch_fault"}, 32'(fetch_fault), 32'(tv[i].f));
      if (tv[i].v || tv[i].rst) begin
        chk({tag, " ifid_ir"}, 32'(ifid_ir), 32'(tv[i].ir));
        chk({tag, " ifid_pc"}, 32'(ifid_pc), 32'(tv[i].pc));
        chk({tag, " ifid_pc_plus2"}, 32'(ifid_pc_plus2), 32'(tv[i].pc + 16'd2 - (tv[i].rst ? 16'd2 : 16'd0)));
      end
      perf_chk(tag, tv[i].pf, tv[i].ps, tv[i].pl);
    end
    // odd redirect target from RUN: one bubble, then the target word with correct pc_plus2
    step(0, 0, 1, 16'h0005);
    chk("redir bubble valid", 32'(ifid_valid), 32'(0));
    chk("redir addr", 32'(imem_addr), 32'h0004);
    step(0, 0, 0, 16'h0000);
    chk("redir target valid", 32'(ifid_valid), 32'(1));
    chk("redir target ir", 32'(ifid_ir), 32'h1002);
    chk("redir target pc", 32'(ifid_pc), 32'h0004);
    chk("redir target pc_plus2", 32'(ifid_pc_plus2), 32'h0006);
    perf_chk("redir", 16'd2, 16'd0, 16'd1);
    // stall in HALT keeps the halt word valid in IF/ID until released
    step(0, 1, 0, 16'h0000);
    chk("halt stall pre valid", 32'(ifid_valid), 32'(1));
    step(0, 0, 0, 16'h0000);
    chk("halt capture ir", 32'(ifid_ir), 32'hFFFF);
    chk("halt capture halted", 32'(halted), 32'(1));
    step(0, 1, 0, 16'h0000);
    chk("halt stalled valid held", 32'(ifid_valid), 32'(1));
    chk("halt stalled addr", 32'(imem_addr), 32'h0006);
    step(0, 0, 0, 16'h0000);
    chk("halt bubble valid", 32'(ifid_valid), 32'(0));
    perf_chk("halt", 16'd3, 16'd1, 16'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
